// File: rtl/round_sequencer_pkg.sv
// Shared game package: FSM state encoding and LFSR constants
// used by the round sequencer and its ms prescaler.
package round_sequencer_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_COUNTDOWN = 3'd1;
   localparam logic [2:0] ST_DELAY     = 3'd2;
   localparam logic [2:0] ST_GO        = 3'd3;
   localparam logic [2:0] ST_RESULT    = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      COUNTDOWN = ST_COUNTDOWN,
      DELAY     = ST_DELAY,
      GO        = ST_GO,
      RESULT    = ST_RESULT
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Taps 16,14,13,11 expressed on a right-shifting register:
   // the feedback bit is the XOR of bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {^(l & LFSR_TAPS), l[15:1]};
   endfunction

endpackage

// File: rtl/round_sequencer_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLKS_PER_MS clocks,
// restartable from zero by clear.
module ms_tick_gen #(
   parameter int CLKS_PER_MS = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

   logic [CW-1:0] cnt;

   // Free-running count that wraps at LAST or restarts on clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Reaction-game round sequencer: countdown, random hold-off,
// GO window and result hold, feeding the score tracker.
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int CLKS_PER_MS    = 100000,
   parameter int COUNTDOWN_SECS = 3,
   parameter int MIN_DELAY_MS   = 1000,
   parameter int RAND_BITS      = 11,
   parameter int TIMEOUT_MS     = 5000,
   parameter int RESULT_MS      = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       round_over,
   output logic       countdown_in_action,
   output logic       round_in_action,
   output logic       delay_done,
   output logic [3:0] countdown_digit,
   output logic       timeout
);

   localparam logic [15:0] SEC_TICKS = 16'd1000;
   localparam logic [15:0] TMO_TICKS = 16'(TIMEOUT_MS);
   localparam logic [15:0] RES_TICKS = 16'(RESULT_MS);
   localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);
   localparam logic [3:0]  FIRST_DIG = 4'(COUNTDOWN_SECS);

   state_t      state, state_n;
   logic [15:0] phase, phase_n;
   logic [15:0] delay_ms, delay_ms_n;
   logic [3:0]  digit_n;
   logic        timeout_n;
   logic        cia_n, ria_n, dd_n;
   logic [15:0] lfsr;
   logic        tick;
   logic        clear;

   ms_tick_gen #(
      .CLKS_PER_MS(CLKS_PER_MS)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   // Prescaler realigns to every state change so phases are whole ms.
   assign clear = (state_n != state);

   // Next-state, phase counter and registered-output decode.
   always_comb begin
      state_n    = state;
      phase_n    = phase;
      delay_ms_n = delay_ms;
      digit_n    = countdown_digit;
      timeout_n  = timeout;
      if (tick)
         phase_n = phase + 16'd1;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = COUNTDOWN;
               digit_n = FIRST_DIG;
            end
         end
         COUNTDOWN: begin
            if (tick && phase == SEC_TICKS - 16'd1) begin
               phase_n = '0;
               if (countdown_digit == 4'd1) begin
                  state_n    = DELAY;
                  digit_n    = 4'd0;
                  delay_ms_n = MIN_DELAY
                             + 16'(lfsr[RAND_BITS-1:0]);
               end else begin
                  digit_n = countdown_digit - 4'd1;
               end
            end
         end
         DELAY: begin
            if (round_over)
               state_n = RESULT;
            else if (tick && phase == delay_ms - 16'd1)
               state_n = GO;
         end
         GO: begin
            if (round_over) begin
               state_n = RESULT;
            end else if (tick && phase == TMO_TICKS - 16'd1) begin
               state_n   = RESULT;
               timeout_n = 1'b1;
            end
         end
         RESULT: begin
            if (tick && phase == RES_TICKS - 16'd1) begin
               state_n   = IDLE;
               timeout_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n != state)
         phase_n = '0;
      cia_n = (state_n == COUNTDOWN);
      ria_n = (state_n == DELAY) || (state_n == GO);
      dd_n  = (state_n == GO);
   end

   // State, phase and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         phase               <= '0;
         delay_ms            <= '0;
         countdown_digit     <= '0;
         timeout             <= 1'b0;
         countdown_in_action <= 1'b0;
         round_in_action     <= 1'b0;
         delay_done          <= 1'b0;
      end else begin
         state               <= state_n;
         phase               <= phase_n;
         delay_ms            <= delay_ms_n;
         countdown_digit     <= digit_n;
         timeout             <= timeout_n;
         countdown_in_action <= cia_n;
         round_in_action     <= ria_n;
         delay_done          <= dd_n;
      end
   end

   // Hold-off randomness: LFSR steps every clock from a nonzero seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= LFSR_SEED;
      else
         lfsr <= lfsr_next(lfsr);
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: expected output-change
// events are queued by the stimulus and consumed by a monitor.
module tb_round_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       round_over;
   logic       countdown_in_action;
   logic       round_in_action;
   logic       delay_done;
   logic [3:0] countdown_digit;
   logic       timeout;

   round_sequencer #(
      .CLKS_PER_MS   (4),
      .COUNTDOWN_SECS(3),
      .MIN_DELAY_MS  (10),
      .RAND_BITS     (3),
      .TIMEOUT_MS    (20),
      .RESULT_MS     (5)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .round_over         (round_over),
      .countdown_in_action(countdown_in_action),
      .round_in_action    (round_in_action),
      .delay_done         (delay_done),
      .countdown_digit    (countdown_digit),
      .timeout            (timeout)
   );

   typedef struct {
      int         cyc;
      logic [7:0] outs;
   } exp_t;

   exp_t       expq[$];
   int         checks   = 0;
   int         failures = 0;
   int         cyc;
   logic [7:0] cur;
   logic [7:0] prev;
   logic [7:0] outs;

   assign outs = {countdown_in_action, round_in_action, delay_done,
                  timeout, countdown_digit};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [7:0] ov(input bit c, input bit r,
                                     input bit d, input bit t,
                                     input logic [3:0] g);
      return {c, r, d, t, g};
   endfunction

   function automatic logic [15:0] lfsr_steps(input int n);
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < n; i++)
         l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      return l;
   endfunction

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, got, req);
      end
   endtask

   task automatic push(input int c, input logic [7:0] o);
      exp_t e;
      e.cyc  = c;
      e.outs = o;
      expq.push_back(e);
   endtask

   task automatic wait_cyc(input int at);
      while (cyc < at) @(negedge clk);
   endtask

   task automatic drive_start(input int at, input int len);
      wait_cyc(at);
      start = 1'b1;
      repeat (len) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive_ro(input int at);
      wait_cyc(at);
      round_over = 1'b1;
      @(negedge clk);
      round_over = 1'b0;
   endtask

   // e is the edge that samples start; k is DELAY entry, g is GO.
   task automatic round_start(input int e, output int k, output int g);
      logic [15:0] v;
      push(e,         ov(1, 0, 0, 0, 4'd3));
      push(e + 4000,  ov(1, 0, 0, 0, 4'd2));
      push(e + 8000,  ov(1, 0, 0, 0, 4'd1));
      push(e + 12000, ov(0, 1, 0, 0, 4'd0));
      k = e + 12000;
      v = lfsr_steps(k - 1);
      g = k + 4 * (10 + int'(v[2:0]));
   endtask

   always @(negedge clk) begin
      cur = outs;
      if (rst) begin
         prev = cur;
      end else if (cur !== prev) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event cyc=%0d actual=%0h required=%0h",
                     cyc, cur, prev);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("event_outs", int'(cur), int'(e.outs));
            chk("event_cyc", cyc, e.cyc);
         end
         prev = cur;
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog cyc=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int k1, g1, k2, g2, k3, g3, k4, g4, k5, g5;
      rst        = 1'b0;
      start      = 1'b0;
      round_over = 1'b0;
      #1 rst = 1'b1;
      #20;
      chk("reset_outs", int'(outs), 0);
      @(negedge clk);
      rst = 1'b0;

      // Round 1: countdown, GO, press 7 clks after GO.
      round_start(10, k1, g1);
      push(g1,     ov(0, 1, 1, 0, 4'd0));
      push(g1 + 7, ov(0, 0, 0, 0, 4'd0));
      drive_start(9, 1);
      drive_start(5010, 1);
      drive_ro(g1 + 6);

      // Round 2: start straddling RESULT->IDLE, then false start.
      round_start(g1 + 28, k2, g2);
      push(k2 + 10, ov(0, 0, 0, 0, 4'd0));
      drive_start(g1 + 26, 2);
      drive_ro(k2 + 9);

      // Round 3: round_over coincides with hold-off expiry.
      round_start(k2 + 31, k3, g3);
      push(g3, ov(0, 0, 0, 0, 4'd0));
      drive_start(k2 + 29, 2);
      drive_ro(g3 - 1);

      // Round 4: no press, timeout.
      round_start(g3 + 21, k4, g4);
      push(g4,       ov(0, 1, 1, 0, 4'd0));
      push(g4 + 80,  ov(0, 0, 0, 1, 4'd0));
      push(g4 + 100, ov(0, 0, 0, 0, 4'd0));
      drive_start(g3 + 19, 2);

      // Round 5: reset while in GO.
      round_start(g4 + 101, k5, g5);
      push(g5, ov(0, 1, 1, 0, 4'd0));
      drive_start(g4 + 100, 1);
      wait_cyc(g5 + 3);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_go_outs", int'(outs), 0);
      chk("rst_mid_go_pending", expq.size(), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // After reset the FSM must be idle and accept start.
      push(10, ov(1, 0, 0, 0, 4'd3));
      drive_start(9, 1);
      wait_cyc(40);
      chk("final_queue_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
